// File: rtl/reg_dump_if.sv
// rtl/reg_dump_if.sv - register-file read port and dump byte stream
interface reg_dump_if #(
  parameter int pw = 3
);
  logic [pw-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output rd_addr,
    input  rd_data,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - streams a wrapping window of register-file bytes out
// over a valid/ready port and keeps a mod-256 checksum of what was sent.
module reg_dump #(
  parameter int pw = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [pw-1:0] base_addr,
  input  logic [pw:0]   count,
  reg_dump_if.master    bus,
  output logic          busy,
  output logic          done,
  output logic [7:0]    checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [pw-1:0] addr_q;
  logic [pw:0]   remaining_q;
  logic [7:0]    out_data_q;
  logic [7:0]    checksum_q;
  logic          xfer;
  logic          last_byte;

  assign xfer      = (state == SEND) && bus.out_ready;
  assign last_byte = (remaining_q == (pw+1)'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) state_nx = READ;
          else             state_nx = FIN;
        end
      end
      READ: state_nx = SEND;
      SEND: begin
        if (xfer) state_nx = last_byte ? FIN : READ;
      end
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address advances only after a byte is accepted, so it still names the
  // byte on offer throughout SEND; pw-bit arithmetic gives the wrap for free.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      checksum_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            checksum_q <= '0;
            if (count != '0) begin
              addr_q      <= base_addr;
              remaining_q <= count;
            end
          end
        end
        READ: out_data_q <= bus.rd_data;
        SEND: begin
          if (bus.out_ready) begin
            checksum_q  <= checksum_q + out_data_q;
            remaining_q <= remaining_q - (pw+1)'(1);
            if (!last_byte) addr_q <= addr_q + pw'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_addr   = addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = (state == SEND);
  assign busy          = (state != IDLE);
  assign done          = (state == FIN);
  assign checksum      = checksum_q;

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 SHALL have parameter pw, default 3, meaning register address width (2**pw registers, 8 for the default).
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a dump; sampled only in IDLE.
REQ-005 SHALL have port base_addr  input  pw  first register index to read; sampled with start.
REQ-006 SHALL have port count  input  pw+1  number of registers to read; sampled with start.
REQ-007 SHALL have port rd_addr  output  pw  read address to the register file read port.
REQ-008 SHALL have port rd_data  input  8  combinational read data returned for rd_addr in the same cycle.
REQ-009 SHALL have port out_data  output  8  dumped register byte.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid byte.
REQ-011 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at end of dump.
REQ-014 SHALL have port checksum  output  8  mod-256 sum of all bytes transferred in the last dump.

Function
REQ-015 SHALL implement states IDLE, READ, SEND, FIN.
REQ-016 IDLE, start=1, count!=0: SHALL latch base_addr into address counter, count into remaining counter, clear checksum, go to READ.
REQ-017 IDLE, start=1, count=0: SHALL clear checksum, go to FIN (no bytes sent).
REQ-018 IDLE, start=0: SHALL stay in IDLE; rd_addr, out_data, checksum hold.
REQ-019 rd_addr SHALL equal the address counter at all times.
REQ-020 READ: SHALL register rd_data into out_data and go to SEND; exactly one READ cycle per byte.
REQ-021 SEND: out_valid SHALL be 1; out_data SHALL be stable until accepted.
REQ-022 Transfer SHALL occur on a cycle with out_valid=1 and out_ready=1; out_ready ignored otherwise.
REQ-023 On transfer: checksum += out_data (mod 256); remaining decremented; if remaining was 1, go to FIN, else address counter +1 and go to READ.
REQ-024 Address increment SHALL wrap mod 2**pw (7 -> 0 for pw=3); count > 2**pw SHALL re-read wrapped registers.
REQ-025 Latency: start accepted in cycle t -> READ at t+1 -> out_valid first high at t+2; with out_ready held high one byte every 2 cycles.
REQ-026 FIN: done SHALL be 1 for exactly one cycle, checksum final and held, next state IDLE.
REQ-027 start while busy=1 SHALL be ignored with no effect on the dump in progress.
REQ-028 out_valid SHALL be 0 in IDLE, READ and FIN.
REQ-029 rd_data SHALL be sampled only in READ; register file changes at other times SHALL not affect the byte already captured.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE, rd_addr=0, out_data=0, out_valid=0, busy=0, done=0, checksum=0, counters=0.
REQ-031 reset SHALL take priority over start, out_ready and all state transitions.
REQ-032 reset during READ/SEND SHALL abort the dump with no done pulse; any byte not yet transferred SHALL be discarded.

Verification
REQ-033 Reg file holds regs 0..7 = 0x10..0x17; start, base=0, count=8, out_ready=1 -> bytes 0x10..0x17 in order, rd_addr 0..7, done pulse, checksum=0x9C.
REQ-034 base=6, count=4, same contents -> bytes 0x16,0x17,0x10,0x11 (wrap), checksum=0x4E.
REQ-035 base=2, count=1, out_ready low 5 cycles in SEND then high -> out_valid high and out_data=0x12 stable all 6 cycles, single transfer, checksum=0x12.
REQ-036 count=0 -> no out_valid, done one cycle after start, checksum=0x00, busy high exactly one cycle.
REQ-037 regs all 0xFF, count=3 -> checksum=0xFD (mod-256 wrap); start pulsed mid-dump -> ignored, exactly 3 bytes.
REQ-038 reset asserted in second SEND of an 8-byte dump -> next cycle IDLE, all outputs 0, no done; new start afterwards dumps normally.
